// File: rtl/hex_panel_pkg.sv
// Shared constants for the hex counter panel: key indices, the active-low
// 7-segment font (bit order {g,f,e,d,c,b,a}) and the digit decoder.
package hex_panel_pkg;

    localparam int NUM_KEYS  = 4;
    localparam int KEY_INC   = 0;
    localparam int KEY_DEC   = 1;
    localparam int KEY_LOAD  = 2;
    localparam int KEY_CLR   = 3;

    localparam int COUNT_W   = 16;
    localparam int SEG_W     = 7;
    localparam int REPEAT_W  = 25;

    // Segment patterns, 0 = lit.
    localparam logic [SEG_W-1:0] SEG_FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    localparam logic [SEG_W-1:0] SEG_ZERO = 7'b1000000;

    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] digit);
        return SEG_FONT[digit];
    endfunction

endpackage

// File: rtl/key_pulse.sv
// Single-key press detector: normalizes polarity, registers the level once,
// keeps a one-sample history and emits a one-cycle pulse on each
// released->pressed edge. The first sample after reset only loads history,
// so a key held through reset never produces an action.
// With AUTOREPEAT_EN defined and REPEAT_EN set, a held key additionally
// pulses after HOLD_CYCLES and then every REPEAT_CYCLES until release.
module key_pulse
    import hex_panel_pkg::*;
#(
    parameter bit ACTIVE_LOW    = 1'b1
`ifdef AUTOREPEAT_EN
  , parameter bit REPEAT_EN     = 1'b0
  , parameter int HOLD_CYCLES   = 25000000
  , parameter int REPEAT_CYCLES = 5000000
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic pulse
);

    logic level;
    logic level_q;
    logic hist_q;
    logic primed_q;
    logic edge_pulse;

    assign level = ACTIVE_LOW ? ~key : key;

    // Register the level; the first post-reset sample seeds history directly.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q  <= 1'b0;
            hist_q   <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            level_q  <= level;
            hist_q   <= primed_q ? level_q : level;
            primed_q <= 1'b1;
        end
    end

    assign edge_pulse = level_q & ~hist_q;

`ifdef AUTOREPEAT_EN
    if (REPEAT_EN) begin : g_repeat
        localparam logic [REPEAT_W-1:0] HOLD_LAST   = REPEAT_W'(HOLD_CYCLES - 1);
        localparam logic [REPEAT_W-1:0] REPEAT_LAST = REPEAT_W'(REPEAT_CYCLES - 1);

        logic [REPEAT_W-1:0] hold_cnt;
        logic                repeating;
        logic                held;
        logic                rep_pulse;

        assign held      = level_q & hist_q;
        assign rep_pulse = held & (repeating ? (hold_cnt == REPEAT_LAST)
                                             : (hold_cnt == HOLD_LAST));

        // Count held cycles; restart after every repeat pulse, clear on release.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hold_cnt  <= '0;
                repeating <= 1'b0;
            end else if (!held) begin
                hold_cnt  <= '0;
                repeating <= 1'b0;
            end else if (rep_pulse) begin
                hold_cnt  <= '0;
                repeating <= 1'b1;
            end else begin
                hold_cnt  <= hold_cnt + 1'b1;
            end
        end

        assign pulse = edge_pulse | rep_pulse;
    end else begin : g_no_repeat
        assign pulse = edge_pulse;
    end
`else
    assign pulse = edge_pulse;
`endif

endmodule

// File: rtl/hex_counter_panel.sv
// 16-bit up/down counter driven by the virtual panel's keys and switches,
// shown in hex on four active-low 7-segment digits.
// KEY0 inc, KEY1 dec, KEY2 load {6'b0,SW}, KEY3 clear; step = SW[3:0] (0 -> 1).
// Optional build macro AUTOREPEAT_EN enables hold-to-repeat on KEY0/KEY1.
module hex_counter_panel
    import hex_panel_pkg::*;
#(
    parameter bit KEY_ACTIVE_LOW = 1'b1,
    parameter int HOLD_CYCLES    = 25000000,
    parameter int REPEAT_CYCLES  = 5000000
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic [9:0]       i_SW,
    input  logic [3:0]       i_KEY,
    output logic [SEG_W-1:0] o_HEX3,
    output logic [SEG_W-1:0] o_HEX2,
    output logic [SEG_W-1:0] o_HEX1,
    output logic [SEG_W-1:0] o_HEX0
);

    if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1 ||
        HOLD_CYCLES >= (1 << REPEAT_W) || REPEAT_CYCLES >= (1 << REPEAT_W)) begin : g_bad_param
        $error("hex_counter_panel: HOLD_CYCLES/REPEAT_CYCLES must fit in 1..2^25-1");
    end

    logic [NUM_KEYS-1:0] pulse;
    logic [COUNT_W-1:0]  count;
    logic [COUNT_W-1:0]  count_next;
    logic [COUNT_W-1:0]  step;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_pulse #(
            .ACTIVE_LOW    (KEY_ACTIVE_LOW)
`ifdef AUTOREPEAT_EN
          , .REPEAT_EN     (k == KEY_INC || k == KEY_DEC)
          , .HOLD_CYCLES   (HOLD_CYCLES)
          , .REPEAT_CYCLES (REPEAT_CYCLES)
`endif
        ) u_key_pulse (
            .clk   (i_CLK),
            .rst   (i_RST),
            .key   (i_KEY[k]),
            .pulse (pulse[k])
        );
    end

    assign step = {12'b0, (i_SW[3:0] == 4'd0) ? 4'd1 : i_SW[3:0]};

    // Priority mux: clear > load > inc/dec; inc and dec together cancel.
    // NOTE: count_next is assigned a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        count_next = count;
        if (pulse[KEY_CLR]) begin
            count_next = '0;
        end else if (pulse[KEY_LOAD]) begin
            count_next = {6'b0, i_SW};
        end else if (pulse[KEY_INC] && !pulse[KEY_DEC]) begin
            count_next = count + step;
        end else if (pulse[KEY_DEC] && !pulse[KEY_INC]) begin
            count_next = count - step;
        end
    end

    // Counter register, wraps modulo 2^16.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    // Registered digit decoders, one cycle behind the counter.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            o_HEX3 <= SEG_ZERO;
            o_HEX2 <= SEG_ZERO;
            o_HEX1 <= SEG_ZERO;
            o_HEX0 <= SEG_ZERO;
        end else begin
            o_HEX3 <= hex_to_seg(count[15:12]);
            o_HEX2 <= hex_to_seg(count[11:8]);
            o_HEX1 <= hex_to_seg(count[7:4]);
            o_HEX0 <= hex_to_seg(count[3:0]);
        end
    end

endmodule
